out_quant_ser: RTL and testbench

OUT_QUANT_SER -- requirements
Module: out_quant_ser

---
 rtl/out_quant_ser.sv | 171 +++++++++++++++++
 tb/tb_out_quant_ser.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/out_quant_ser.sv
// Output quantiser/serialiser: shifts and saturates n accumulator lanes to p-bit unsigned
// codes, then streams them as n-wide bit-planes, MSB first, over a valid/ready port.
`timescale 1ns/1ps
module out_quant_ser #(
  parameter int unsigned n = 64,
  parameter int unsigned w = 32
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [n*w-1:0] din,
  input  logic [4:0]     shamt,
  input  logic [2:0]     prec,
  output logic           busy,
  output logic           ovalid,
  input  logic           oready,
  output logic [n-1:0]   odata,
  output logic           olast
);

  localparam int unsigned QW = 8;
  localparam int unsigned KW = 3;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_QUANT = 2'd2,
    S_EMIT  = 2'd3
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic                 w_hs;

  logic [n-1:0][w-1:0]  r_acc;
  logic [4:0]           r_shamt;
  logic [2:0]           r_prec;
  logic [n-1:0][w-1:0]  w_shifted;

  logic [3:0]           w_p;
  logic [QW-1:0]        w_mask;
  logic [n-1:0][QW-1:0] w_q;
  logic [n-1:0][QW-1:0] r_q;
  logic [KW-1:0]        r_k;
  logic [KW-1:0]        w_k_dec;
  logic [n-1:0]         w_plane_first;
  logic [n-1:0]         w_plane_next;

  logic                 r_busy;
  logic                 r_ovalid;
  logic                 r_olast;
  logic [n-1:0]         r_odata;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode; a plane is consumed only on a valid/ready handshake
  always_comb begin
    w_state_nxt = r_state;
    w_hs        = 1'b0;
    case (r_state)
      S_IDLE:  if (start) w_state_nxt = S_LOAD;
      S_LOAD:  w_state_nxt = S_QUANT;
      S_QUANT: w_state_nxt = S_EMIT;
      S_EMIT: begin
        w_hs = r_ovalid & oready;
        if (w_hs && (r_k == '0)) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Arithmetic right shift; amounts at or beyond w leave only sign bits
  always_comb begin
    w_shifted = '0;
    for (int unsigned i = 0; i < n; i++) begin
      w_shifted[i] = w'($signed(r_acc[i]) >>> r_shamt);
    end
  end

  // Saturate to [0, 2^p-1]; a non-negative lane overflows iff any bit at or above p is set
  always_comb begin
    w_p    = 4'(r_prec) + 4'd1;
    w_mask = QW'((9'd1 << w_p) - 9'd1);
    w_q    = '0;
    for (int unsigned i = 0; i < n; i++) begin
      if (!r_acc[i][w-1]) begin
        if ((r_acc[i] >> w_p) != '0) begin
          w_q[i] = w_mask;
        end else begin
          w_q[i] = r_acc[i][QW-1:0] & w_mask;
        end
      end
    end
  end

  // First plane comes straight from the fresh codes; later planes from the stored codes
  always_comb begin
    w_k_dec       = r_k - KW'(1);
    w_plane_first = '0;
    w_plane_next  = '0;
    for (int unsigned i = 0; i < n; i++) begin
      w_plane_first[i] = w_q[i][r_prec];
      w_plane_next[i]  = r_q[i][w_k_dec];
    end
  end

  // Job operands; captured only when a start is accepted, so later input changes are ignored
  always_ff @(posedge clk) begin
    if (r_state == S_IDLE && start && !rst) begin
      r_acc   <= din;
      r_shamt <= shamt;
      r_prec  <= prec;
    end else if (r_state == S_LOAD) begin
      r_acc   <= w_shifted;
    end
  end

  // Codes, plane index and registered output port
  always_ff @(posedge clk) begin
    if (rst) begin
      r_q      <= '0;
      r_k      <= '0;
      r_busy   <= 1'b0;
      r_ovalid <= 1'b0;
      r_olast  <= 1'b0;
      r_odata  <= '0;
    end else begin
      r_busy <= (w_state_nxt != S_IDLE);
      case (r_state)
        S_QUANT: begin
          r_q      <= w_q;
          r_k      <= r_prec;
          r_ovalid <= 1'b1;
          r_odata  <= w_plane_first;
          r_olast  <= (r_prec == 3'd0);
        end
        S_EMIT: begin
          if (w_hs) begin
            if (r_k == '0) begin
              r_ovalid <= 1'b0;
              r_olast  <= 1'b0;
              r_odata  <= '0;
            end else begin
              r_k     <= w_k_dec;
              r_odata <= w_plane_next;
              r_olast <= (r_k == KW'(1));
            end
          end
        end
        default: begin
          r_ovalid <= 1'b0;
          r_olast  <= 1'b0;
          r_odata  <= '0;
        end
      endcase
    end
  end

  assign busy   = r_busy;
  assign ovalid = r_ovalid;
  assign olast  = r_olast;
  assign odata  = r_odata;

endmodule

// File: tb/tb_out_quant_ser.sv
// Self-checking bench for out_quant_ser (n=4, w=32): directed vector table, hand-written
// corner sequences and random jobs checked against an arithmetic reference model.
`timescale 1ns/1ps
module tb_out_quant_ser;

  localparam int unsigned N = 4;
  localparam int unsigned W = 32;

  logic           clk = 1'b0;
  logic           rst;
  logic           start;
  logic [N*W-1:0] din;
  logic [4:0]     shamt;
  logic [2:0]     prec;
  logic           busy;
  logic           ovalid;
  logic           oready;
  logic [N-1:0]   odata;
  logic           olast;

  int errors = 0;
  int checks = 0;

  logic [N-1:0] got_p[$];
  logic         got_l[$];
  logic [N-1:0] exp_p[$];

  typedef struct packed {
    logic [N*W-1:0]      din;
    logic [4:0]          shamt;
    logic [2:0]          prec;
    logic [7:0][N-1:0]   planes;
  } vec_t;

  vec_t tbl[5];

  out_quant_ser #(.n(N), .w(W)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .din    (din),
    .shamt  (shamt),
    .prec   (prec),
    .busy   (busy),
    .ovalid (ovalid),
    .oready (oready),
    .odata  (odata),
    .olast  (olast)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Reference: shift, clamp to [0, 2^p-1], then list bit p-1 .. bit 0 of every lane
  task automatic model_job(input logic [N*W-1:0] d, input int sh, input int p);
    int q[N];
    exp_p.delete();
    for (int i = 0; i < N; i++) begin
      int v;
      longint a;
      v = int'(d[i*W +: W]);
      a = longint'(v) >>> sh;
      if (a < 0) q[i] = 0;
      else if (a > longint'((1 << p) - 1)) q[i] = (1 << p) - 1;
      else q[i] = int'(a);
    end
    for (int j = 0; j < p; j++) begin
      logic [N-1:0] pl;
      for (int i = 0; i < N; i++) pl[i] = q[i][p-1-j];
      exp_p.push_back(pl);
    end
  endtask

  task automatic table_exp(input int idx);
    exp_p.delete();
    for (int j = 0; j <= int'(tbl[idx].prec); j++) exp_p.push_back(tbl[idx].planes[j]);
  endtask

  task automatic rand_inputs();
    for (int i = 0; i < N; i++) din[i*W +: W] = $urandom;
    shamt = 5'($urandom);
    prec  = 3'($urandom);
  endtask

  // Issue one job from IDLE and collect planes; optional stall window, random ready, start spam
  task automatic do_job(input string nm, input logic [N*W-1:0] d, input logic [4:0] s,
                        input logic [2:0] pr, input int stall_at, input int stall_n,
                        input bit rand_ready, input bit hold_start);
    int cyc;
    int stall_left;
    bit stalled;
    logic [N-1:0] sv_d;
    logic sv_l;
    got_p.delete();
    got_l.delete();
    din = d; shamt = s; prec = pr; start = 1'b1; oready = 1'b0;
    @(posedge clk); #1;
    start = hold_start;
    rand_inputs();
    chk({nm, "_busy_load"}, 64'(busy), 64'd1);
    chk({nm, "_lat_e1"}, 64'(ovalid), 64'd0);
    @(posedge clk); #1;
    if (hold_start) rand_inputs();
    chk({nm, "_lat_e2"}, 64'(ovalid), 64'd0);
    @(posedge clk); #1;
    chk({nm, "_lat_e3"}, 64'(ovalid), 64'd1);
    cyc = 0; stall_left = stall_n; stalled = 1'b0; sv_d = '0; sv_l = 1'b0;
    while (ovalid === 1'b1 && cyc < 300) begin
      if (hold_start) rand_inputs();
      if (got_p.size() == stall_at && stall_left > 0) begin
        if (!stalled) begin
          sv_d = odata; sv_l = olast; stalled = 1'b1;
        end else begin
          chk({nm, "_stall_data"}, 64'(odata), 64'(sv_d));
          chk({nm, "_stall_last"}, 64'(olast), 64'(sv_l));
        end
        oready = 1'b0;
        stall_left--;
      end else begin
        oready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
        if (oready) begin
          got_p.push_back(odata);
          got_l.push_back(olast);
        end
      end
      @(posedge clk); #1;
      cyc++;
    end
    oready = 1'b0;
    start  = 1'b0;
    if (cyc >= 300) chk({nm, "_timeout"}, 64'd1, 64'd0);
    chk({nm, "_busy_done"}, 64'(busy), 64'd0);
    chk({nm, "_nplanes"}, 64'(got_p.size()), 64'(exp_p.size()));
    for (int j = 0; j < got_p.size() && j < exp_p.size(); j++) begin
      chk($sformatf("%s_plane%0d", nm, j), 64'(got_p[j]), 64'(exp_p[j]));
      chk($sformatf("%s_last%0d", nm, j), 64'(got_l[j]), 64'(j == exp_p.size() - 1));
    end
  endtask

  initial begin
    tbl[0].din = {32'd2, 32'd300, 32'hFFFF_FFFD, 32'd5};
    tbl[0].shamt = 5'd0; tbl[0].prec = 3'd2; tbl[0].planes = '0;
    tbl[0].planes[0] = 4'b0101; tbl[0].planes[1] = 4'b1100; tbl[0].planes[2] = 4'b0101;

    tbl[1].din = {32'd17, 32'd255, 32'hFFFF_FFC0, 32'd64};
    tbl[1].shamt = 5'd4; tbl[1].prec = 3'd3; tbl[1].planes = '0;
    tbl[1].planes[0] = 4'b0100; tbl[1].planes[1] = 4'b0101;
    tbl[1].planes[2] = 4'b0100; tbl[1].planes[3] = 4'b1100;

    tbl[2].din = {32'hFFFF_FF9C, 32'd100, 32'h7FFF_FFFF, 32'hFFFF_FFFF};
    tbl[2].shamt = 5'd31; tbl[2].prec = 3'd0; tbl[2].planes = '0;

    tbl[3].din = {32'd0, 32'hFFFF_FFFF, 32'd2, 32'd1};
    tbl[3].shamt = 5'd0; tbl[3].prec = 3'd0; tbl[3].planes = '0;
    tbl[3].planes[0] = 4'b0011;

    tbl[4].din = {32'd200, 32'hFFFF_FFFE, 32'd511, 32'd1000};
    tbl[4].shamt = 5'd1; tbl[4].prec = 3'd7; tbl[4].planes = '0;
    tbl[4].planes[0] = 4'b0011; tbl[4].planes[1] = 4'b1011;
    tbl[4].planes[2] = 4'b1011; tbl[4].planes[3] = 4'b0011;
    tbl[4].planes[4] = 4'b0011; tbl[4].planes[5] = 4'b1011;
    tbl[4].planes[6] = 4'b0011; tbl[4].planes[7] = 4'b0011;

    rst = 1'b1; start = 1'b0; oready = 1'b0; din = '0; shamt = '0; prec = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_ovalid", 64'(ovalid), 64'd0);
    chk("rst_olast", 64'(olast), 64'd0);
    chk("rst_odata", 64'(odata), 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int t = 0; t < 5; t++) begin
      table_exp(t);
      do_job($sformatf("tbl%0d", t), tbl[t].din, tbl[t].shamt, tbl[t].prec, -1, 0, 1'b0, 1'b0);
    end

    // Backpressure: hold the second plane for five cycles
    table_exp(1);
    do_job("bp", tbl[1].din, tbl[1].shamt, tbl[1].prec, 1, 5, 1'b0, 1'b0);

    // Start pulsed through LOAD/QUANT/EMIT is ignored; back-to-back start right after is taken
    table_exp(0);
    do_job("busy_start", tbl[0].din, tbl[0].shamt, tbl[0].prec, 1, 2, 1'b0, 1'b1);
    table_exp(4);
    do_job("b2b", tbl[4].din, tbl[4].shamt, tbl[4].prec, -1, 0, 1'b0, 1'b0);

    // Reset while the first of four planes is pending
    din = tbl[1].din; shamt = tbl[1].shamt; prec = tbl[1].prec; start = 1'b1; oready = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 0; c < 10 && ovalid !== 1'b1; c++) begin
      @(posedge clk); #1;
    end
    chk("rst_emit_pre_valid", 64'(ovalid), 64'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst_emit_busy", 64'(busy), 64'd0);
    chk("rst_emit_ovalid", 64'(ovalid), 64'd0);
    chk("rst_emit_odata", 64'(odata), 64'd0);
    chk("rst_emit_olast", 64'(olast), 64'd0);
    oready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      chk($sformatf("rst_emit_quiet%0d", c), 64'(ovalid), 64'd0);
    end
    oready = 1'b0;

    // Reset outranks a simultaneous start
    din = tbl[0].din; shamt = tbl[0].shamt; prec = tbl[0].prec; start = 1'b1; rst = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; rst = 1'b0;
    chk("rst_start_busy", 64'(busy), 64'd0);
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      chk($sformatf("rst_start_quiet%0d", c), 64'(ovalid), 64'd0);
    end

    table_exp(1);
    do_job("post_rst", tbl[1].din, tbl[1].shamt, tbl[1].prec, -1, 0, 1'b0, 1'b0);

    // Random jobs against the reference model
    for (int r = 0; r < 40; r++) begin
      logic [N*W-1:0] d;
      logic [4:0] s;
      logic [2:0] pr;
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 3) == 0) d[i*W +: W] = $urandom;
        else d[i*W +: W] = 32'($urandom_range(0, 8191)) - 32'd4096;
      end
      s  = ($urandom_range(0, 7) == 0) ? 5'($urandom) : 5'($urandom_range(0, 6));
      pr = 3'($urandom);
      model_job(d, int'(s), int'(pr) + 1);
      do_job($sformatf("rnd%0d", r), d, s, pr, int'($urandom_range(0, 8)),
             int'($urandom_range(0, 3)), 1'b1, 1'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
